// File: rtl/stabilize_pkg.sv
// Shared constants, types and helpers for the stabilization BRV generator.
package stabilize_pkg;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_RST  = 16'hACE1;

    typedef enum logic {
        READY  = 1'b0,
        COMMIT = 1'b1
    } cfg_state_t;

    // Linear reset threshold for interior level j+1: ((j+1)*65536)/wmax, truncated.
    function automatic logic [15:0] default_thresh(input int j, input int wres);
        longint num;
        num = ((longint'(j) + 64'sd1) * 64'sd65536) / ((64'sd1 <<< wres) - 64'sd1);
        return num[15:0];
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
        logic [31:0] d;
        d = {v, v} << (n & 15);
        return d[31:16];
    endfunction

endpackage

// File: rtl/stabilize_brv_gen_if.sv
// Control, config handshake and BRV output bundle of stabilize_brv_gen.
interface stabilize_brv_gen_if #(
    parameter int WRES   = 3,
    parameter int LFSR_W = 16
);
    localparam int NLVL = 2**WRES - 2;

    logic              en;
    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic              cfg_valid;
    logic [WRES-1:0]   cfg_idx;
    logic [LFSR_W-1:0] cfg_thresh;
    logic              cfg_ready;
    logic              cfg_err;
    logic [NLVL-1:0]   F_brv;
    logic              brv_valid;

    modport master (
        output en, seed_load, seed, cfg_valid, cfg_idx, cfg_thresh,
        input  cfg_ready, cfg_err, F_brv, brv_valid
    );

    modport slave (
        input  en, seed_load, seed, cfg_valid, cfg_idx, cfg_thresh,
        output cfg_ready, cfg_err, F_brv, brv_valid
    );
endinterface

// File: rtl/lfsr16_galois.sv
// 16-bit right-shift Galois LFSR; load has priority and never enters the all-zero state.
module lfsr16_galois
    import stabilize_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] state
);
    logic [15:0] state_q, state_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (en) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_POLY : 16'h0000);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LFSR_RST;
        else     state_q <= state_d;
    end

    assign state = state_q;
endmodule

// File: rtl/stabilize_brv_gen.sv
// Per-level Bernoulli random vector for STDP weight stabilization: rotated LFSR views
// compared against programmable thresholds, with a two-state config write handshake.
module stabilize_brv_gen
    import stabilize_pkg::*;
#(
    parameter int WRES   = 3,
    parameter int LFSR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    stabilize_brv_gen_if.slave  bus
);
    localparam int NLVL = 2**WRES - 2;

    logic [LFSR_W-1:0] lfsr_cur;
    logic [LFSR_W-1:0] thresh_q [NLVL];
    logic [LFSR_W-1:0] thresh_d [NLVL];
    logic [NLVL-1:0]   brv_q, brv_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    cfg_state_t        state_q, state_d;

    lfsr16_galois u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .load  (bus.seed_load),
        .seed  (bus.seed),
        .state (lfsr_cur)
    );

    // Each level sees a different rotation so the bits are not trivially correlated.
    always_comb begin
        brv_d   = brv_q;
        valid_d = bus.en;
        if (bus.en) begin
            for (int j = 0; j < NLVL; j++) begin
                brv_d[j] = (rotl16(lfsr_cur, (3 * j) % 16) < thresh_q[j]);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        thresh_d = thresh_q;
        err_d    = err_q;
        case (state_q)
            READY: begin
                if (bus.cfg_valid) begin
                    state_d = COMMIT;
                    if (int'(bus.cfg_idx) < NLVL) thresh_d[bus.cfg_idx] = bus.cfg_thresh;
                    else                          err_d = 1'b1;
                end
            end
            COMMIT:  state_d = READY;
            default: state_d = READY;
        endcase
    end

    // NOTE: the threshold file is reset explicitly because its defaults define the
    // generator's behaviour before any configuration write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= READY;
            err_q   <= 1'b0;
            brv_q   <= '0;
            valid_q <= 1'b0;
            for (int j = 0; j < NLVL; j++) thresh_q[j] <= default_thresh(j, WRES);
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            brv_q    <= brv_d;
            valid_q  <= valid_d;
            thresh_q <= thresh_d;
        end
    end

    assign bus.cfg_ready = (state_q == READY);
    assign bus.cfg_err   = err_q;
    assign bus.F_brv     = brv_q;
    assign bus.brv_valid = valid_q;
endmodule

// File: tb/tb_stabilize_brv_gen.sv
// Randomized self-checking bench for stabilize_brv_gen against a behavioural reference model.
module tb_stabilize_brv_gen;
    localparam int NLVL = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stabilize_brv_gen_if #(.WRES(3), .LFSR_W(16)) bus ();

    stabilize_brv_gen #(.WRES(3), .LFSR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    int unsigned m_lfsr;
    int unsigned m_T [NLVL];
    logic [NLVL-1:0] m_brv;
    logic m_valid, m_err, m_ready;
    int unsigned dflt [NLVL] = '{9362, 18724, 28086, 37449, 46811, 56173};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned lfsr_next(input int unsigned v);
        return (v / 2) ^ ((v % 2 == 1) ? 32'hB400 : 32'h0);
    endfunction

    function automatic int unsigned rot(input int unsigned v, input int n);
        return ((v * (32'd1 << n)) % 65536) + (v >> (16 - n));
    endfunction

    task automatic m_reset();
        m_lfsr  = 32'hACE1;
        m_brv   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ready = 1'b1;
        for (int j = 0; j < NLVL; j++) m_T[j] = dflt[j];
    endtask

    task automatic cycle();
        logic [NLVL-1:0] nb;
        int unsigned nl;
        logic accept;
        nb = m_brv;
        if (bus.en) for (int j = 0; j < NLVL; j++) nb[j] = (rot(m_lfsr, (3 * j) % 16) < m_T[j]);
        nl = m_lfsr;
        if (bus.seed_load) nl = (bus.seed == 16'h0) ? 32'h1 : 32'(bus.seed);
        else if (bus.en)   nl = lfsr_next(m_lfsr);
        accept = bus.cfg_valid && m_ready;
        @(posedge clk);
        #1;
        m_brv   = nb;
        m_valid = bus.en;
        m_lfsr  = nl;
        if (accept) begin
            if (bus.cfg_idx < 3'(NLVL)) m_T[bus.cfg_idx] = 32'(bus.cfg_thresh);
            else                        m_err = 1'b1;
            m_ready = 1'b0;
        end else begin
            m_ready = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".F_brv"},     32'(bus.F_brv),     32'(m_brv));
        check({tag, ".brv_valid"}, 32'(bus.brv_valid), 32'(m_valid));
        check({tag, ".cfg_ready"}, 32'(bus.cfg_ready), 32'(m_ready));
        check({tag, ".cfg_err"},   32'(bus.cfg_err),   32'(m_err));
        check({tag, ".lfsr"},      32'(dut.lfsr_cur),  m_lfsr);
    endtask

    task automatic check_thresh(input string tag);
        for (int j = 0; j < NLVL; j++) check(tag, 32'(dut.thresh_q[j]), m_T[j]);
    endtask

    task automatic idle();
        bus.en = 1'b0; bus.seed_load = 1'b0; bus.seed = '0;
        bus.cfg_valid = 1'b0; bus.cfg_idx = '0; bus.cfg_thresh = '0;
    endtask

    initial begin
        int cnt [NLVL];
        int first_ret;
        logic [NLVL-1:0] exp_first;

        idle();
        m_reset();
        #12 rst = 1'b0;

        // Reset state.
        check("rst.F_brv", 32'(bus.F_brv), 32'h0);
        check("rst.brv_valid", 32'(bus.brv_valid), 32'h0);
        check("rst.cfg_ready", 32'(bus.cfg_ready), 32'h1);
        check("rst.cfg_err", 32'(bus.cfg_err), 32'h0);
        check("rst.lfsr", 32'(dut.lfsr_cur), 32'hACE1);
        for (int j = 0; j < NLVL; j++) check("rst.thresh", 32'(dut.thresh_q[j]), dflt[j]);

        // First enabled step from the reset seed.
        exp_first = '0;
        for (int j = 0; j < NLVL; j++) exp_first[j] = (rot(32'hACE1, (3 * j) % 16) < dflt[j]);
        bus.en = 1'b1;
        cycle();
        check("en1.lfsr", 32'(dut.lfsr_cur), 32'hE270);
        check("en1.F_brv", 32'(bus.F_brv), 32'(exp_first));
        check_all("en1");
        bus.en = 1'b0;
        cycle();
        check_all("hold");

        // Zero seed maps to 1, then advances to the polynomial mask.
        bus.seed_load = 1'b1; bus.seed = 16'h0;
        cycle();
        check("seed0.lfsr", 32'(dut.lfsr_cur), 32'h0001);
        bus.seed_load = 1'b0; bus.en = 1'b1;
        cycle();
        check("seed0.step", 32'(dut.lfsr_cur), 32'hB400);
        bus.seed_load = 1'b1; bus.seed = 16'h1234;
        cycle();
        check("seed_en.lfsr", 32'(dut.lfsr_cur), 32'h1234);
        check_all("seed_en");
        idle();

        // T[2]=0 write, then bit 2 must never fire.
        bus.cfg_valid = 1'b1; bus.cfg_idx = 3'd2; bus.cfg_thresh = 16'h0;
        cycle();
        bus.cfg_valid = 1'b0;
        check("wr.ready_low", 32'(bus.cfg_ready), 32'h0);
        cycle();
        check("wr.ready_back", 32'(bus.cfg_ready), 32'h1);
        bus.en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            check("t0.bit2", 32'(bus.F_brv[2]), 32'h0);
            if (i % 50 == 0) check_all("t0");
        end
        idle();

        // Out-of-range write: handshake completes, error sticks, thresholds untouched.
        bus.cfg_valid = 1'b1; bus.cfg_idx = 3'd6; bus.cfg_thresh = 16'hFFFF;
        cycle();
        bus.cfg_valid = 1'b0;
        check_all("oor");
        check("oor.err", 32'(bus.cfg_err), 32'h1);
        check_thresh("oor.thresh");
        for (int i = 0; i < 5; i++) cycle();
        check("oor.sticky", 32'(bus.cfg_err), 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bus.en         = ($urandom_range(0, 3) != 0);
            bus.seed_load  = ($urandom_range(0, 15) == 0);
            bus.seed       = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            bus.cfg_valid  = ($urandom_range(0, 2) == 0);
            bus.cfg_idx    = 3'($urandom_range(0, 7));
            bus.cfg_thresh = 16'($urandom);
            cycle();
            check_all("rand");
        end
        check_thresh("rand.thresh");
        idle();

        // Asynchronous reset while in COMMIT with en high.
        bus.cfg_valid = 1'b1; bus.cfg_idx = 3'd0; bus.cfg_thresh = 16'h0005; bus.en = 1'b1;
        cycle();
        bus.cfg_valid = 1'b0;
        check("commit.ready", 32'(bus.cfg_ready), 32'h0);
        rst = 1'b1;
        #1;
        m_reset();
        check_all("arst");
        #1 rst = 1'b0;
        check_thresh("arst.thresh");
        for (int j = 0; j < NLVL; j++) check("arst.dflt", 32'(dut.thresh_q[j]), dflt[j]);

        // Full period at default thresholds.
        for (int j = 0; j < NLVL; j++) cnt[j] = 0;
        first_ret = 0;
        bus.en = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            cycle();
            for (int j = 0; j < NLVL; j++) cnt[j] += int'(bus.F_brv[j]);
            if (first_ret == 0 && dut.lfsr_cur == 16'hACE1) first_ret = i;
        end
        check_all("period");
        check("period.len", 32'(first_ret), 32'd65535);
        for (int j = 0; j < NLVL; j++) begin
            check("period.ones_2pct",
                  32'((cnt[j] * 50 >= int'(dflt[j]) * 49) && (cnt[j] * 50 <= int'(dflt[j]) * 51)),
                  32'h1);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
